// File: rtl/sample_word_packer.sv
// Packs a stream of 24-bit samples MSB-first into 768-bit words with a sample count.
// An accumulator fills while the previously packed word waits for data_ack.
module sample_word_packer #(
    parameter int SAMPLE_W         = 24,
    parameter int SAMPLES_PER_WORD = 32,
    parameter int WORD_W           = SAMPLE_W * SAMPLES_PER_WORD,
    parameter int CNT_W            = 6,
    parameter int FRAME_CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SAMPLE_W-1:0]    in_sample,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [WORD_W-1:0]      fifo_data,
    output logic [CNT_W-1:0]       num_samples,
    output logic                   data_ready,
    input  logic                   data_ack,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLES_PER_WORD);

    logic [CNT_W-1:0]       acc_cnt_reg;
    logic [CNT_W-1:0]       acc_cnt_next;
    logic                   flush_pending_reg;
    logic                   flush_pending_next;
    logic [WORD_W-1:0]      acc_data;
    logic [WORD_W-1:0]      fifo_data_reg;
    logic [CNT_W-1:0]       num_samples_reg;
    logic                   data_ready_reg;
    logic                   data_ready_next;
    logic [FRAME_CNT_W-1:0] frame_count_reg;

    logic acc_full;
    logic acc_empty;
    logic slot_free;
    logic accept;
    logic move;
    logic in_ready_int;

    assign acc_full     = (acc_cnt_reg == FULL_CNT);
    assign acc_empty    = (acc_cnt_reg == '0);
    assign slot_free    = !data_ready_reg || data_ack;
    assign in_ready_int = !reset && !acc_full && !flush_pending_reg;
    assign accept       = in_valid && in_ready_int;
    // Accepting and moving are mutually exclusive: a move needs a full
    // accumulator or a pending flush, and both hold in_ready low.
    assign move         = (acc_full || (flush_pending_reg && !acc_empty)) && slot_free;

    // Per-slot sample registers; slot 0 lands in the most significant bits.
    for (genvar gi = 0; gi < SAMPLES_PER_WORD; gi++) begin : g_slot
        logic [SAMPLE_W-1:0] slot_reg;
        logic                slot_load;

        assign slot_load = accept && (acc_cnt_reg == CNT_W'(gi));

        always_ff @(posedge clk) begin
            if (reset || move) begin
                slot_reg <= '0;
            end else if (slot_load) begin
                slot_reg <= in_sample;
            end
        end

        assign acc_data[WORD_W-1-gi*SAMPLE_W -: SAMPLE_W] = slot_reg;
    end

    always_comb begin
        acc_cnt_next = acc_cnt_reg;
        if (move) begin
            acc_cnt_next = '0;
        end else if (accept) begin
            acc_cnt_next = acc_cnt_reg + CNT_W'(1);
        end
    end

    // A flush request that finds an empty accumulator simply lapses.
    always_comb begin
        flush_pending_next = flush || (flush_pending_reg && !move && !acc_empty);
    end

    // A move with a simultaneous ack keeps data_ready high: no bubble between words.
    always_comb begin
        data_ready_next = data_ready_reg;
        if (move) begin
            data_ready_next = 1'b1;
        end else if (data_ack) begin
            data_ready_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt_reg       <= '0;
            flush_pending_reg <= 1'b0;
            fifo_data_reg     <= '0;
            num_samples_reg   <= '0;
            data_ready_reg    <= 1'b0;
            frame_count_reg   <= '0;
        end else begin
            acc_cnt_reg       <= acc_cnt_next;
            flush_pending_reg <= flush_pending_next;
            data_ready_reg    <= data_ready_next;
            if (move) begin
                fifo_data_reg   <= acc_data;
                num_samples_reg <= acc_cnt_reg;
                frame_count_reg <= frame_count_reg + FRAME_CNT_W'(1);
            end
        end
    end

    assign in_ready    = in_ready_int;
    assign fifo_data   = fifo_data_reg;
    assign num_samples = num_samples_reg;
    assign data_ready  = data_ready_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_sample_word_packer.sv
// Directed self-checking bench for sample_word_packer; one task per scenario.
module tb_sample_word_packer;

    logic         clk;
    logic         reset;
    logic [23:0]  in_sample;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [767:0] fifo_data;
    logic [5:0]   num_samples;
    logic         data_ready;
    logic         data_ack;
    logic [15:0]  frame_count;

    integer checks;
    integer errors;
    logic [15:0] exp_frames;

    sample_word_packer dut (
        .clk         (clk),
        .reset       (reset),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .fifo_data   (fifo_data),
        .num_samples (num_samples),
        .data_ready  (data_ready),
        .data_ack    (data_ack),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds a sample on the input until it is accepted; optionally pulses flush in the accept cycle.
    task automatic send_sample(input logic [23:0] v, input logic with_flush);
        int waited;
        waited = 0;
        in_sample = v;
        in_valid  = 1'b1;
        while (!in_ready && waited < 200) begin
            step();
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout sample %h never accepted (in_ready=%b, required 1)", v, in_ready);
        end
        if (with_flush) flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        step();
        step();
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready got %b exp 0", data_ready); end
        checks++;
        if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d exp 0", frame_count); end
        checks++;
        if (num_samples !== 6'd0) begin errors++; $display("FAIL reset_num_samples got %0d exp 0", num_samples); end
        checks++;
        if (fifo_data !== 768'd0) begin errors++; $display("FAIL reset_fifo_data got %h exp 0", fifo_data); end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
        exp_frames = 16'd0;
        $display("reset done");
    endtask

    task automatic test_full_word();
        for (int i = 1; i <= 32; i++) send_sample(24'(i), 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_low got %b exp 0", in_ready); end
        step();
        exp_frames = exp_frames + 16'd1;
        $display("word frame=%0d num=%0d top=%h", frame_count, num_samples, fifo_data[767:744]);
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL full_data_ready got %b exp 1", data_ready); end
        checks++;
        if (fifo_data[767:744] !== 24'h000001) begin errors++; $display("FAIL full_slot0 got %h exp 000001", fifo_data[767:744]); end
        checks++;
        if (fifo_data[647:624] !== 24'h000006) begin errors++; $display("FAIL full_slot5 got %h exp 000006", fifo_data[647:624]); end
        checks++;
        if (fifo_data[23:0] !== 24'h000020) begin errors++; $display("FAIL full_slot31 got %h exp 000020", fifo_data[23:0]); end
        checks++;
        if (num_samples !== 6'd32) begin errors++; $display("FAIL full_num_samples got %0d exp 32", num_samples); end
        checks++;
        if (frame_count !== exp_frames) begin errors++; $display("FAIL full_frame_count got %0d exp %0d", frame_count, exp_frames); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_back got %b exp 1", in_ready); end
    endtask

    task automatic test_backpressure();
        for (int i = 33; i <= 64; i++) send_sample(24'(i), 1'b0);
        in_sample = 24'h000041;
        in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b exp 0", c, in_ready); end
        end
        checks++;
        if (fifo_data[767:744] !== 24'h000001 || num_samples !== 6'd32)
            begin errors++; $display("FAIL stall_hold got top %h num %0d exp 000001 32", fifo_data[767:744], num_samples); end
        checks++;
        if (frame_count !== exp_frames) begin errors++; $display("FAIL stall_frame_count got %0d exp %0d", frame_count, exp_frames); end
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
        in_valid = 1'b0;
        exp_frames = exp_frames + 16'd1;
        $display("word frame=%0d num=%0d top=%h", frame_count, num_samples, fifo_data[767:744]);
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL bp_data_ready got %b exp 1", data_ready); end
        checks++;
        if (fifo_data[767:744] !== 24'h000021) begin errors++; $display("FAIL bp_slot0 got %h exp 000021", fifo_data[767:744]); end
        checks++;
        if (fifo_data[23:0] !== 24'h000040) begin errors++; $display("FAIL bp_slot31 got %h exp 000040", fifo_data[23:0]); end
        checks++;
        if (frame_count !== exp_frames) begin errors++; $display("FAIL bp_frame_count got %0d exp %0d", frame_count, exp_frames); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got %b exp 1", in_ready); end
        data_ack = 1'b1;
        step();
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL drain_data_ready got %b exp 0", data_ready); end
        step();
        data_ack = 1'b0;
        checks++;
        if (data_ready !== 1'b0 || frame_count !== exp_frames)
            begin errors++; $display("FAIL idle_ack got ready %b frames %0d exp 0 %0d", data_ready, frame_count, exp_frames); end
    endtask

    task automatic test_flush_partial();
        logic [119:0] exp_part;
        for (int i = 0; i < 5; i++) exp_part[119-i*24 -: 24] = 24'hA00001 + 24'(i);
        for (int i = 0; i < 5; i++) send_sample(24'hA00001 + 24'(i), (i == 4));
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pending_in_ready got %b exp 0", in_ready); end
        step();
        exp_frames = exp_frames + 16'd1;
        $display("word frame=%0d num=%0d top=%h", frame_count, num_samples, fifo_data[767:744]);
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL flush_data_ready got %b exp 1", data_ready); end
        checks++;
        if (num_samples !== 6'd5) begin errors++; $display("FAIL flush_num_samples got %0d exp 5", num_samples); end
        checks++;
        if (fifo_data[767:648] !== exp_part) begin errors++; $display("FAIL flush_samples got %h exp %h", fifo_data[767:648], exp_part); end
        checks++;
        if (fifo_data[647:0] !== 648'd0) begin errors++; $display("FAIL flush_zero_tail got nonzero exp 0"); end
        checks++;
        if (frame_count !== exp_frames) begin errors++; $display("FAIL flush_frame_count got %0d exp %0d", frame_count, exp_frames); end
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
    endtask

    task automatic test_flush_empty();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL empty_flush_pending got %b exp 0", in_ready); end
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_flush_in_ready got %b exp 1", in_ready); end
        step();
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL empty_flush_data_ready got %b exp 0", data_ready); end
        checks++;
        if (frame_count !== exp_frames) begin errors++; $display("FAIL empty_flush_frames got %0d exp %0d", frame_count, exp_frames); end
        $display("empty flush frames=%0d", frame_count);
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 32; i++) send_sample(24'h500000 + 24'(i), 1'b0);
        for (int i = 1; i <= 10; i++) send_sample(24'h600000 + 24'(i), 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (data_ready !== 1'b0 || num_samples !== 6'd0 || frame_count !== 16'd0 || fifo_data !== 768'd0)
            begin errors++; $display("FAIL midreset_outputs got ready %b num %0d frames %0d exp 0 0 0", data_ready, num_samples, frame_count); end
        exp_frames = 16'd0;
        for (int i = 1; i <= 32; i++) send_sample(24'hB00000 + 24'(i), 1'b0);
        step();
        exp_frames = exp_frames + 16'd1;
        $display("word frame=%0d num=%0d top=%h", frame_count, num_samples, fifo_data[767:744]);
        checks++;
        if (fifo_data[767:744] !== 24'hB00001) begin errors++; $display("FAIL midreset_slot0 got %h exp B00001", fifo_data[767:744]); end
        checks++;
        if (fifo_data[23:0] !== 24'hB00020 || num_samples !== 6'd32)
            begin errors++; $display("FAIL midreset_slot31 got %h num %0d exp B00020 32", fifo_data[23:0], num_samples); end
        checks++;
        if (frame_count !== exp_frames) begin errors++; $display("FAIL midreset_frames got %0d exp %0d", frame_count, exp_frames); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 32; i++) send_sample(24'hD00000 + 24'(i), 1'b0);
        checks++;
        if (data_ready !== 1'b1 || in_ready !== 1'b0)
            begin errors++; $display("FAIL b2b_pre got ready %b in_ready %b exp 1 0", data_ready, in_ready); end
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
        exp_frames = exp_frames + 16'd1;
        $display("word frame=%0d num=%0d top=%h", frame_count, num_samples, fifo_data[767:744]);
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL b2b_data_ready got %b exp 1", data_ready); end
        checks++;
        if (fifo_data[767:744] !== 24'hD00001 || fifo_data[23:0] !== 24'hD00020)
            begin errors++; $display("FAIL b2b_word got %h..%h exp D00001..D00020", fifo_data[767:744], fifo_data[23:0]); end
        checks++;
        if (frame_count !== exp_frames) begin errors++; $display("FAIL b2b_frames got %0d exp %0d", frame_count, exp_frames); end
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", data_ready); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_frames = 16'd0;
        reset      = 1'b1;
        in_sample  = '0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        data_ack   = 1'b0;
        test_reset();
        test_full_word();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
